// File: rtl/decode_alu_dcache.sv
// decode_alu_dcache: single-cycle LEGv8-subset execute slice.
// The instruction decoder/controller and the 64-bit ALU are combinational.
// The word-addressed data memory reads combinationally and writes on the
// rising clock edge.
// Ports:
//   clock, reset       clock and asynchronous active-high reset (clears memory)
//   instruction        current instruction word
//   read_data1/2       register file operands (Rn, Rm/Rt)
//   reg2loc..regwrite  control bits
//   aluop              00 mem, 01 CBZ, 10 R-type
//   read_register1/2   register file read addresses
//   write_register     write-back register address
//   sign_extend        sign-extended immediate
//   alu_result, zero   ALU output (also the memory byte address) and zero flag
//   mem_read_data      memory word at alu_result
//   writeback_data     memtoreg ? mem_read_data : alu_result
//   illegal            opcode is not in the supported set
module decode_alu_dcache #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              reg2loc,
    output logic              uncondbranch,
    output logic              branch,
    output logic              memread,
    output logic              memtoreg,
    output logic              memwrite,
    output logic              alusrc,
    output logic              regwrite,
    output logic [1:0]        aluop,
    output logic [4:0]        read_register1,
    output logic [4:0]        read_register2,
    output logic [4:0]        write_register,
    output logic [DATA_W-1:0] sign_extend,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] writeback_data,
    output logic              illegal
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;

    logic [10:0]       opcode;
    logic              is_b;
    logic              is_cbz;
    logic              is_dtype;
    logic [DATA_W-1:0] operand_b;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign opcode   = instruction[31:21];
    assign is_b     = (instruction[31:26] == 6'b000101);
    assign is_cbz   = (instruction[31:24] == 8'hB4);
    assign is_dtype = (opcode == OP_LDUR) || (opcode == OP_STUR);

    // Controller: B and CBZ are matched on their short opcodes first.
    always_comb begin
        reg2loc      = 1'b0;
        uncondbranch = 1'b0;
        branch       = 1'b0;
        memread      = 1'b0;
        memtoreg     = 1'b0;
        memwrite     = 1'b0;
        alusrc       = 1'b0;
        regwrite     = 1'b0;
        aluop        = 2'b00;
        illegal      = 1'b0;
        if (is_b) begin
            uncondbranch = 1'b1;
        end else if (is_cbz) begin
            reg2loc = 1'b1;
            branch  = 1'b1;
            aluop   = 2'b01;
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    regwrite = 1'b1;
                    aluop    = 2'b10;
                end
                OP_LDUR: begin
                    memread  = 1'b1;
                    memtoreg = 1'b1;
                    alusrc   = 1'b1;
                    regwrite = 1'b1;
                end
                OP_STUR: begin
                    reg2loc  = 1'b1;
                    memwrite = 1'b1;
                    alusrc   = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign read_register1 = instruction[9:5];
    assign read_register2 = reg2loc ? instruction[4:0] : instruction[20:16];
    assign write_register = instruction[4:0];

    // Immediate field selection by instruction format.
    always_comb begin
        sign_extend = '0;
        if (is_b) begin
            sign_extend = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
        end else if (is_cbz) begin
            sign_extend = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
        end else if (is_dtype) begin
            sign_extend = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
        end
    end

    assign operand_b = alusrc ? sign_extend : read_data2;

    // ALU: address add, CBZ pass-through, or R-type op chosen by opcode.
    always_comb begin
        alu_result = read_data1 + operand_b;
        case (aluop)
            2'b01: alu_result = operand_b;
            2'b10: begin
                case (opcode)
                    OP_SUB:  alu_result = read_data1 - operand_b;
                    OP_AND:  alu_result = read_data1 & operand_b;
                    OP_ORR:  alu_result = read_data1 | operand_b;
                    default: alu_result = read_data1 + operand_b;
                endcase
            end
            default: alu_result = read_data1 + operand_b;
        endcase
    end

    assign zero = (alu_result == '0);

    // Word index: byte offset dropped, upper address bits wrap.
    assign mem_idx        = alu_result[IDX_W+2:3];
    assign mem_read_data  = mem[mem_idx];
    assign writeback_data = memtoreg ? mem_read_data : alu_result;

    // Data memory: async clear, store on rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (memwrite) begin
            mem[mem_idx] <= read_data2;
        end
    end

endmodule

// File: tb/tb_decode_alu_dcache.sv
// tb_decode_alu_dcache: directed and randomized checks of decode_alu_dcache
// against an instruction-level reference model with its own word memory.
module tb_decode_alu_dcache;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic [63:0] read_data1 = '0;
    logic [63:0] read_data2 = '0;
    logic        reg2loc, uncondbranch, branch, memread, memtoreg, memwrite;
    logic        alusrc, regwrite, zero, illegal;
    logic [1:0]  aluop;
    logic [4:0]  read_register1, read_register2, write_register;
    logic [63:0] sign_extend, alu_result, mem_read_data, writeback_data;

    int total = 0;
    int bad   = 0;

    logic [63:0] ref_mem [32];

    typedef struct packed {
        logic [7:0]  ctl;     // r2l,ub,br,mr,m2r,mw,src,rw
        logic [1:0]  aluop;
        logic        ill;
        logic [63:0] sext;
        logic [63:0] res;
        logic [63:0] mdata;
        logic [63:0] wb;
        logic [4:0]  rr2;
    } exp_t;

    decode_alu_dcache #(.DATA_W(64), .DEPTH(32)) dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .read_data1(read_data1), .read_data2(read_data2),
        .reg2loc(reg2loc), .uncondbranch(uncondbranch), .branch(branch),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
        .alusrc(alusrc), .regwrite(regwrite), .aluop(aluop),
        .read_register1(read_register1), .read_register2(read_register2),
        .write_register(write_register), .sign_extend(sign_extend),
        .alu_result(alu_result), .zero(zero), .mem_read_data(mem_read_data),
        .writeback_data(writeback_data), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction-level model: classify, then compute results arithmetically.
    function automatic exp_t predict(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [10:0] op;
        op = ins[31:21];
        e = '0;
        if (ins[31:26] == 6'b000101) begin
            e.ctl  = 8'b0100_0000;
            e.sext = 64'($signed(ins[25:0]));
            e.res  = a + b;
        end else if (ins[31:24] == 8'hB4) begin
            e.ctl   = 8'b1010_0000;
            e.aluop = 2'd1;
            e.sext  = 64'($signed(ins[23:5]));
            e.res   = b;
        end else if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
            e.ctl   = 8'b0000_0001;
            e.aluop = 2'd2;
            if (op == 11'h458)      e.res = a + b;
            else if (op == 11'h658) e.res = a - b;
            else if (op == 11'h450) e.res = a & b;
            else                    e.res = a | b;
        end else if (op == 11'h7C2) begin
            e.ctl  = 8'b0001_1011;
            e.sext = 64'($signed(ins[20:12]));
            e.res  = a + e.sext;
        end else if (op == 11'h7C0) begin
            e.ctl  = 8'b1000_0110;
            e.sext = 64'($signed(ins[20:12]));
            e.res  = a + e.sext;
        end else begin
            e.ill = 1'b1;
            e.res = a + b;
        end
        e.mdata = ref_mem[int'((e.res >> 3) % 64'd32)];
        e.wb    = e.ctl[3] ? e.mdata : e.res;
        e.rr2   = e.ctl[7] ? ins[4:0] : ins[20:16];
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        instruction = ins;
        read_data1  = a;
        read_data2  = b;
        #1;
    endtask

    task automatic check_model(input string tag);
        exp_t e;
        e = predict(instruction, read_data1, read_data2);
        check({tag, ".ctl"}, 64'({reg2loc, uncondbranch, branch, memread, memtoreg,
                                 memwrite, alusrc, regwrite}), 64'(e.ctl));
        check({tag, ".aluop"}, 64'(aluop), 64'(e.aluop));
        check({tag, ".illegal"}, 64'(illegal), 64'(e.ill));
        check({tag, ".sext"}, sign_extend, e.sext);
        check({tag, ".res"}, alu_result, e.res);
        check({tag, ".zero"}, 64'(zero), 64'(e.res == 64'd0));
        check({tag, ".mdata"}, mem_read_data, e.mdata);
        check({tag, ".wb"}, writeback_data, e.wb);
        check({tag, ".regs"}, 64'({read_register1, read_register2, write_register}),
              64'({instruction[9:5], e.rr2, instruction[4:0]}));
    endtask

    // One rising edge; the model stores if the instruction is a store.
    task automatic clock_edge();
        exp_t e;
        e = predict(instruction, read_data1, read_data2);
        @(posedge clock);
        if (!reset && e.ctl[2]) ref_mem[int'((e.res >> 3) % 64'd32)] = read_data2;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 8))
            0: r[31:21] = 11'h458;
            1: r[31:21] = 11'h658;
            2: r[31:21] = 11'h450;
            3: r[31:21] = 11'h550;
            4: r[31:21] = 11'h7C2;
            5: r[31:21] = 11'h7C0;
            6: r[31:24] = 8'hB4;
            7: r[31:26] = 6'b000101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] a, b;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // Reset state: memory reads zero while reset is held.
        drive(32'hF84083E1, 64'h10, 64'h0);
        check("reset_mem", mem_read_data, 64'h0);
        #11;
        reset = 1'b0;
        @(posedge clock);
        #1;

        drive(32'h8B020020, 64'd5, 64'd7);
        check("add.res", alu_result, 64'd12);
        check("add.rw", 64'(regwrite), 64'd1);
        check("add.zero", 64'(zero), 64'd0);
        check("add.wb", writeback_data, 64'd12);
        check_model("add");

        drive(32'hCB020020, 64'd9, 64'd9);
        check("sub.res", alu_result, 64'd0);
        check("sub.zero", 64'(zero), 64'd1);

        drive(32'hAA020020, 64'hF0, 64'h0F);
        check("orr.res", alu_result, 64'hFF);

        drive(32'hF80083E1, 64'h10, 64'hDEAD);
        check("stur.mw", 64'(memwrite), 64'd1);
        check_model("stur");
        clock_edge();
        drive(32'hF84083E1, 64'h10, 64'h0);
        check("ldur.mdata", mem_read_data, 64'hDEAD);
        check("ldur.wb", writeback_data, 64'hDEAD);
        check_model("ldur");

        drive(32'hB4000040, 64'h1234, 64'd0);
        check("cbz.br", 64'(branch), 64'd1);
        check("cbz.zero", 64'(zero), 64'd1);
        check("cbz.sext", sign_extend, 64'd2);
        drive(32'hB4000040, 64'h1234, 64'd3);
        check("cbz.nz", 64'(zero), 64'd0);

        drive(32'h17FFFFFF, 64'd1, 64'd2);
        check("b.ub", 64'(uncondbranch), 64'd1);
        check("b.sext", sign_extend, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset after a store clears it.
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        reset = 1'b0;
        drive(32'hF84083E1, 64'h10, 64'h0);
        check("rst.ld", mem_read_data, 64'h0);

        drive(32'h00000000, 64'd4, 64'd4);
        check("ill.ill", 64'(illegal), 64'd1);
        check("ill.mw", 64'(memwrite), 64'd0);
        check("ill.rw", 64'(regwrite), 64'd0);
        clock_edge();
        check_model("ill");

        // Store with reset raised mid-cycle is dropped.
        drive(32'hF80083E1, 64'h10, 64'hBEEF);
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
        drive(32'hF84083E1, 64'h10, 64'h0);
        check("rst.drop", mem_read_data, 64'h0);

        // Randomized traffic; small Rn values keep addresses colliding.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            drive(rand_instr(), a, b);
            check_model("rnd");
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #1;
                for (int i = 0; i < 32; i++) ref_mem[i] = '0;
                check_model("rnd_rst");
                clock_edge();
                reset = 1'b0;
            end else begin
                clock_edge();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
